// File: rtl/hwpe_ctrl_periph2reqrsp.sv
// Periph (req/gnt) target to reqrsp (Q/P valid/ready) initiator bridge.
// An ID FIFO remembers each accepted request's periph ID so the response can echo it.
module hwpe_ctrl_periph2reqrsp #(
    parameter int unsigned AW            = 32,
    parameter int unsigned DW            = 32,
    parameter int unsigned ID_WIDTH      = 8,
    parameter int unsigned NbOutstanding = 2
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clear_i,
    // periph target side
    input  logic                periph_req_i,
    output logic                periph_gnt_o,
    input  logic [AW-1:0]       periph_add_i,
    input  logic                periph_wen_i,
    input  logic [DW/8-1:0]     periph_be_i,
    input  logic [DW-1:0]       periph_data_i,
    input  logic [ID_WIDTH-1:0] periph_id_i,
    output logic [DW-1:0]       periph_r_data_o,
    output logic                periph_r_valid_o,
    output logic [ID_WIDTH-1:0] periph_r_id_o,
    // reqrsp initiator side
    output logic [AW-1:0]       q_addr_o,
    output logic                q_write_o,
    output logic [DW/8-1:0]     q_strb_o,
    output logic [DW-1:0]       q_data_o,
    output logic                q_valid_o,
    input  logic                q_ready_i,
    input  logic [DW-1:0]       p_data_i,
    input  logic                p_valid_i,
    output logic                p_ready_o,
    output logic                idle_o
);

    localparam int unsigned PTR_W = (NbOutstanding > 1) ? $clog2(NbOutstanding) : 1;
    localparam int unsigned CNT_W = $clog2(NbOutstanding + 1);

    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NbOutstanding - 1);
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(NbOutstanding);

    logic [ID_WIDTH-1:0] id_fifo [NbOutstanding];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    count;

    logic full;
    logic empty;
    logic accept;
    logic pop;

    logic                r_valid;
    logic [DW-1:0]       r_data;
    logic [ID_WIDTH-1:0] r_id;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
        // Explicit wrap keeps non-power-of-2 depths correct.
        if (ptr == LAST_PTR) begin
            return '0;
        end
        return ptr + PTR_W'(1);
    endfunction

    assign full   = (count == MAX_CNT);
    assign empty  = (count == '0);
    assign idle_o = empty;

    // Request path is purely combinational; no grant while full, even if a pop is pending.
    assign q_valid_o    = periph_req_i & ~full;
    assign periph_gnt_o = periph_req_i & ~full & q_ready_i;
    assign q_addr_o     = periph_add_i;
    assign q_write_o    = ~periph_wen_i;
    assign q_strb_o     = periph_be_i;
    assign q_data_o     = periph_data_i;

    assign accept = q_valid_o & q_ready_i;
    // A P beat with nothing outstanding is dropped.
    assign pop    = p_valid_i & ~empty;

    assign p_ready_o = 1'b1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({accept, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept) begin
            id_fifo[wr_ptr] <= periph_id_i;
        end
    end

    // Response stage: one cycle after the P beat.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_id    <= '0;
        end else if (clear_i) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= pop;
            if (pop) begin
                r_data <= p_data_i;
                r_id   <= id_fifo[rd_ptr];
            end
        end
    end

    assign periph_r_valid_o = r_valid;
    assign periph_r_data_o  = r_data;
    assign periph_r_id_o    = r_id;

`ifndef SYNTHESIS
    assert property (@(posedge clk_i) disable iff (!rst_ni) p_valid_i |-> !empty)
        else $error("p_valid_i received with no outstanding transaction");
    assert property (@(posedge clk_i) disable iff (!rst_ni) clear_i |-> empty)
        else $error("clear_i asserted while transactions are outstanding");
`endif

endmodule

// File: tb/tb_hwpe_ctrl_periph2reqrsp.sv
// Directed testbench for hwpe_ctrl_periph2reqrsp with hand-computed expectations.
module tb_hwpe_ctrl_periph2reqrsp;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 8;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          clear_i = 1'b0;
    logic          periph_req_i = 1'b0;
    logic          periph_gnt_o;
    logic [AW-1:0] periph_add_i = '0;
    logic          periph_wen_i = 1'b1;
    logic [3:0]    periph_be_i = 4'hF;
    logic [DW-1:0] periph_data_i = '0;
    logic [IW-1:0] periph_id_i = '0;
    logic [DW-1:0] periph_r_data_o;
    logic          periph_r_valid_o;
    logic [IW-1:0] periph_r_id_o;
    logic [AW-1:0] q_addr_o;
    logic          q_write_o;
    logic [3:0]    q_strb_o;
    logic [DW-1:0] q_data_o;
    logic          q_valid_o;
    logic          q_ready_i = 1'b1;
    logic [DW-1:0] p_data_i = '0;
    logic          p_valid_i = 1'b0;
    logic          p_ready_o;
    logic          idle_o;

    int n_cmp = 0;
    int n_err = 0;

    hwpe_ctrl_periph2reqrsp #(
        .AW(AW), .DW(DW), .ID_WIDTH(IW), .NbOutstanding(2)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
        .periph_req_i(periph_req_i), .periph_gnt_o(periph_gnt_o),
        .periph_add_i(periph_add_i), .periph_wen_i(periph_wen_i),
        .periph_be_i(periph_be_i), .periph_data_i(periph_data_i),
        .periph_id_i(periph_id_i), .periph_r_data_o(periph_r_data_o),
        .periph_r_valid_o(periph_r_valid_o), .periph_r_id_o(periph_r_id_o),
        .q_addr_o(q_addr_o), .q_write_o(q_write_o), .q_strb_o(q_strb_o),
        .q_data_o(q_data_o), .q_valid_o(q_valid_o), .q_ready_i(q_ready_i),
        .p_data_i(p_data_i), .p_valid_i(p_valid_i), .p_ready_o(p_ready_o),
        .idle_o(idle_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        // Reset values
        #2;
        chk("rst_idle", 64'(idle_o), 64'd1);
        chk("rst_rvalid", 64'(periph_r_valid_o), 64'd0);
        chk("rst_rdata", 64'(periph_r_data_o), 64'd0);
        chk("rst_rid", 64'(periph_r_id_o), 64'd0);
        chk("rst_qvalid", 64'(q_valid_o), 64'd0);
        chk("rst_gnt", 64'(periph_gnt_o), 64'd0);
        chk("p_ready", 64'(p_ready_o), 64'd1);
        tick();
        tick();
        rst_ni = 1'b1;
        tick();

        // Single read
        periph_req_i = 1'b1; periph_add_i = 32'h10; periph_wen_i = 1'b1;
        periph_id_i = 8'h5A; q_ready_i = 1'b1;
        #1;
        chk("rd_gnt", 64'(periph_gnt_o), 64'd1);
        chk("rd_qvalid", 64'(q_valid_o), 64'd1);
        chk("rd_qwrite", 64'(q_write_o), 64'd0);
        chk("rd_qaddr", 64'(q_addr_o), 64'h10);
        tick();
        periph_req_i = 1'b0;
        chk("rd_busy", 64'(idle_o), 64'd0);
        tick();
        tick();
        p_valid_i = 1'b1; p_data_i = 32'hDEADBEEF;
        #1;
        chk("rd_rvalid_pre", 64'(periph_r_valid_o), 64'd0);
        tick();
        p_valid_i = 1'b0;
        chk("rd_rvalid", 64'(periph_r_valid_o), 64'd1);
        chk("rd_rdata", 64'(periph_r_data_o), 64'hDEADBEEF);
        chk("rd_rid", 64'(periph_r_id_o), 64'h5A);
        chk("rd_idle", 64'(idle_o), 64'd1);
        tick();
        chk("rd_rvalid_drop", 64'(periph_r_valid_o), 64'd0);
        chk("rd_rdata_hold", 64'(periph_r_data_o), 64'hDEADBEEF);

        // Write with strobe
        periph_req_i = 1'b1; periph_wen_i = 1'b0; periph_be_i = 4'h3;
        periph_data_i = 32'h1234; periph_id_i = 8'h21; periph_add_i = 32'h24;
        #1;
        chk("wr_qwrite", 64'(q_write_o), 64'd1);
        chk("wr_strb", 64'(q_strb_o), 64'h3);
        chk("wr_qdata", 64'(q_data_o), 64'h1234);
        chk("wr_gnt", 64'(periph_gnt_o), 64'd1);
        tick();
        periph_req_i = 1'b0;
        p_valid_i = 1'b1; p_data_i = 32'hCAFE;
        tick();
        p_valid_i = 1'b0;
        chk("wr_rvalid", 64'(periph_r_valid_o), 64'd1);
        chk("wr_rid", 64'(periph_r_id_o), 64'h21);
        chk("wr_rdata", 64'(periph_r_data_o), 64'hCAFE);

        // Backpressure
        periph_wen_i = 1'b1; periph_be_i = 4'hF;
        q_ready_i = 1'b0; periph_req_i = 1'b1; periph_id_i = 8'h33;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("bp_gnt", 64'(periph_gnt_o), 64'd0);
            chk("bp_qvalid", 64'(q_valid_o), 64'd1);
            tick();
        end
        chk("bp_idle", 64'(idle_o), 64'd1);
        q_ready_i = 1'b1;
        #1;
        chk("bp_gnt_rise", 64'(periph_gnt_o), 64'd1);
        tick();
        periph_req_i = 1'b0;
        chk("bp_busy", 64'(idle_o), 64'd0);
        p_valid_i = 1'b1; p_data_i = 32'h7;
        tick();
        p_valid_i = 1'b0;
        chk("bp_rid", 64'(periph_r_id_o), 64'h33);

        // Full stall
        periph_req_i = 1'b1; periph_id_i = 8'h01;
        #1;
        chk("fs_gnt1", 64'(periph_gnt_o), 64'd1);
        tick();
        periph_id_i = 8'h02;
        #1;
        chk("fs_gnt2", 64'(periph_gnt_o), 64'd1);
        tick();
        periph_id_i = 8'h03;
        #1;
        chk("fs_full_qvalid", 64'(q_valid_o), 64'd0);
        chk("fs_full_gnt", 64'(periph_gnt_o), 64'd0);
        p_valid_i = 1'b1; p_data_i = 32'h101;
        #1;
        chk("fs_pop_qvalid", 64'(q_valid_o), 64'd0);
        chk("fs_pop_gnt", 64'(periph_gnt_o), 64'd0);
        tick();
        p_valid_i = 1'b0;
        chk("fs_r1_valid", 64'(periph_r_valid_o), 64'd1);
        chk("fs_r1_id", 64'(periph_r_id_o), 64'h01);
        chk("fs_r1_data", 64'(periph_r_data_o), 64'h101);
        chk("fs_gnt3", 64'(periph_gnt_o), 64'd1);
        tick();
        periph_req_i = 1'b0;
        p_valid_i = 1'b1; p_data_i = 32'h102;
        tick();
        chk("fs_r2_id", 64'(periph_r_id_o), 64'h02);
        p_data_i = 32'h103;
        tick();
        p_valid_i = 1'b0;
        chk("fs_r3_valid", 64'(periph_r_valid_o), 64'd1);
        chk("fs_r3_id", 64'(periph_r_id_o), 64'h03);
        chk("fs_r3_data", 64'(periph_r_data_o), 64'h103);
        chk("fs_idle", 64'(idle_o), 64'd1);

        // Wrap and concurrency: one accept and one P beat per cycle
        for (int cyc = 0; cyc <= 10; cyc++) begin
            periph_req_i = (cyc < 10);
            periph_id_i  = 8'(cyc);
            p_valid_i    = (cyc >= 1);
            p_data_i     = 32'h1000 + 32'(cyc) - 32'd1;
            #1;
            if (cyc < 10) chk("wr_gnt_cyc", 64'(periph_gnt_o), 64'd1);
            tick();
            if (cyc >= 1) begin
                chk("wrap_rvalid", 64'(periph_r_valid_o), 64'd1);
                chk("wrap_rid", 64'(periph_r_id_o), 64'(cyc - 1));
                chk("wrap_rdata", 64'(periph_r_data_o), 64'h1000 + 64'(cyc) - 64'd1);
            end
        end
        p_valid_i = 1'b0;
        chk("wrap_idle", 64'(idle_o), 64'd1);
        tick();
        chk("wrap_rvalid_end", 64'(periph_r_valid_o), 64'd0);

        // Reset mid-flight
        periph_req_i = 1'b1; periph_id_i = 8'h44;
        tick();
        periph_id_i = 8'h45;
        tick();
        periph_req_i = 1'b0;
        p_valid_i = 1'b1; p_data_i = 32'h55;
        tick();
        p_valid_i = 1'b0;
        chk("mr_rvalid_pre", 64'(periph_r_valid_o), 64'd1);
        chk("mr_busy", 64'(idle_o), 64'd0);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("mr_idle", 64'(idle_o), 64'd1);
        chk("mr_rvalid", 64'(periph_r_valid_o), 64'd0);
        chk("mr_rid", 64'(periph_r_id_o), 64'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
        periph_req_i = 1'b1; periph_id_i = 8'h77;
        #1;
        chk("mr_gnt", 64'(periph_gnt_o), 64'd1);
        tick();
        periph_req_i = 1'b0;
        p_valid_i = 1'b1; p_data_i = 32'h88;
        tick();
        p_valid_i = 1'b0;
        chk("mr_new_rvalid", 64'(periph_r_valid_o), 64'd1);
        chk("mr_new_rid", 64'(periph_r_id_o), 64'h77);
        chk("mr_new_rdata", 64'(periph_r_data_o), 64'h88);
        chk("mr_new_idle", 64'(idle_o), 64'd1);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not reach end, expected completion");
        $fatal(1);
    end

endmodule
